spimem_arbiter: RTL and testbench



---
 rtl/spimem_arb_pkg.sv | 28 ++
 rtl/spimem_arbiter_if.sv | 36 +++
 rtl/spimem_arb_grant.sv | 47 ++++
 rtl/spimem_arbiter.sv | 131 +++++++++++++
 tb/tb_spimem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spimem_arb_pkg.sv
// spimem_arb_pkg -- shared types and constants for the spimemio read arbiter.
//   state_t    : arbiter FSM states (IDLE, BUSY, RESP)
//   P_IFETCH   : port index of the instruction-fetch requester (port 0)
//   P_DATA     : port index of the data-load requester (port 1)
//   ADDR_W     : flash byte-address width
//   DATA_W     : read data width
//   word_align : clears addr[1:0] so only whole words reach spimemio
package spimem_arb_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    localparam logic P_IFETCH = 1'b0;
    localparam logic P_DATA   = 1'b1;

    localparam logic [ADDR_W-1:0] WORD_MASK = 24'hFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/spimem_arbiter_if.sv
// spimem_arbiter_if -- bundle of the two requester ports and the spimemio port.
//   p0_* : instruction-fetch requester (valid/addr in, ready/rdata out)
//   p1_* : data-load requester (valid/addr in, ready/rdata out)
//   mem_*: spimemio read port (valid/addr out, ready/rdata in)
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding system's view (requesters + spimemio)
interface spimem_arbiter_if;
    import spimem_arb_pkg::*;

    logic              p0_valid;
    logic              p0_ready;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_valid;
    logic              p1_ready;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_valid, p0_addr, p1_valid, p1_addr, mem_ready, mem_rdata,
        output p0_ready, p0_rdata, p1_ready, p1_rdata, mem_valid, mem_addr
    );

    modport master (
        output p0_valid, p0_addr, p1_valid, p1_addr, mem_ready, mem_rdata,
        input  p0_ready, p0_rdata, p1_ready, p1_rdata, mem_valid, mem_addr
    );

endinterface

// File: rtl/spimem_arb_grant.sv
// spimem_arb_grant -- combinational grant decision for the two-port arbiter.
// Optional feature macro: SPIMEM_ARB_STREAM_EN (adds stream-affinity inputs).
//   req0, req1  : qualified requests of port 0 / port 1
//   last_grant  : port granted most recently
//   burst_cnt   : consecutive grants to last_grant while the other port waited
//   hit0, hit1  : (SPIMEM_ARB_STREAM_EN only) port address continues the
//                 flash's current sequential stream
//   grant_vld   : some port is requesting
//   grant       : selected port index
module spimem_arb_grant
    import spimem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    input  logic [7:0] burst_cnt,
`ifdef SPIMEM_ARB_STREAM_EN
    input  logic       hit0,
    input  logic       hit1,
`endif
    output logic       grant_vld,
    output logic       grant
);

    always_comb begin
        grant_vld = req0 | req1;
        grant     = P_IFETCH;
        if (req0 && req1) begin
            // Burst limit beats everything so a streaming port cannot starve
            // the other one; affinity beats plain round-robin.
            if (burst_cnt == 8'(MAX_BURST)) begin
                grant = ~last_grant;
`ifdef SPIMEM_ARB_STREAM_EN
            end else if (hit0 != hit1) begin
                grant = hit1;
`endif
            end else begin
                grant = ~last_grant;
            end
        end else if (req1) begin
            grant = P_DATA;
        end
    end

endmodule

// File: rtl/spimem_arbiter.sv
// spimem_arbiter -- shares one spimemio read port between instruction fetch
// (port 0) and data load (port 1), one outstanding word read at a time.
// Optional feature macro: SPIMEM_ARB_STREAM_EN -- prefer the port whose
// address continues the previous read so spimemio can stay in its
// sequential-read mode.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : spimem_arbiter_if.slave (p0_*, p1_*, mem_* signals)
// Parameters:
//   MAX_BURST : max consecutive grants to one port while the other waits (1..255)
module spimem_arbiter
    import spimem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               reset,
    spimem_arbiter_if.slave    bus
);

    state_t     state_reg, state_next;
    // last_grant_reg doubles as the currently granted port while BUSY/RESP.
    logic       last_grant_reg;
    logic [7:0] burst_cnt_reg;

    logic       req0, req1;
    logic       grant_vld, grant;

    // A port's valid is not looked at in its own response cycle.
    assign req0 = bus.p0_valid && !bus.p0_ready;
    assign req1 = bus.p1_valid && !bus.p1_ready;

`ifdef SPIMEM_ARB_STREAM_EN
    logic [ADDR_W-1:0] stream_addr_reg;
    logic              stream_vld_reg;
    logic              hit0, hit1;

    assign hit0 = stream_vld_reg && (word_align(bus.p0_addr) == stream_addr_reg);
    assign hit1 = stream_vld_reg && (word_align(bus.p1_addr) == stream_addr_reg);
`endif

    spimem_arb_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_grant (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_reg),
        .burst_cnt  (burst_cnt_reg),
`ifdef SPIMEM_ARB_STREAM_EN
        .hit0       (hit0),
        .hit1       (hit1),
`endif
        .grant_vld  (grant_vld),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_vld) state_next = BUSY;
            BUSY:    if (bus.mem_ready) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_valid  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.p0_ready   <= 1'b0;
            bus.p1_ready   <= 1'b0;
            bus.p0_rdata   <= '0;
            bus.p1_rdata   <= '0;
            last_grant_reg <= P_DATA;
            burst_cnt_reg  <= 8'd0;
`ifdef SPIMEM_ARB_STREAM_EN
            stream_addr_reg <= '0;
            stream_vld_reg  <= 1'b0;
`endif
        end else begin
            // Response strobes last exactly one cycle (the RESP state).
            bus.p0_ready <= 1'b0;
            bus.p1_ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_vld) begin
                        bus.mem_valid  <= 1'b1;
                        bus.mem_addr   <= word_align(grant ? bus.p1_addr : bus.p0_addr);
                        last_grant_reg <= grant;
                        if (!(req0 && req1)) begin
                            burst_cnt_reg <= 8'd0;
                        end else if (grant != last_grant_reg) begin
                            burst_cnt_reg <= 8'd1;
                        end else if (burst_cnt_reg != 8'hFF) begin
                            burst_cnt_reg <= burst_cnt_reg + 8'd1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        if (last_grant_reg == P_DATA) begin
                            bus.p1_rdata <= bus.mem_rdata;
                            bus.p1_ready <= 1'b1;
                        end else begin
                            bus.p0_rdata <= bus.mem_rdata;
                            bus.p0_ready <= 1'b1;
                        end
`ifdef SPIMEM_ARB_STREAM_EN
                        // 24-bit add wraps 0xFFFFFC back to 0x000000.
                        stream_addr_reg <= bus.mem_addr + 24'd4;
                        stream_vld_reg  <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spimem_arbiter.sv
// tb_spimem_arbiter -- self-checking bench for spimem_arbiter.
// Exercises single requests from a vector table, round-robin, stream
// affinity / burst limit, address wrap and reset during a busy read.
// Expectations follow SPIMEM_ARB_STREAM_EN when it is defined.
module tb_spimem_arbiter;
    import spimem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spimem_arbiter_if bus ();

    spimem_arbiter #(
        .MAX_BURST (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Memory model configuration.
    int          mem_lat    = 2;
    logic        use_fixed  = 1'b0;
    logic [31:0] fixed_data = 32'h0;
    int          busy_cnt   = 0;

    // Scoreboards: expected read data per port, pushed when a request is driven.
    logic [31:0] sb_q0[$];
    logic [31:0] sb_q1[$];
    int          grant_order[$];

    // Gap monitor state.
    int   low_run   = 0;
    logic seen_high = 1'b0;

    typedef struct {
        logic        port;
        logic [23:0] addr;
        int          lat;
        logic [31:0] data;
        logic [23:0] exp_addr;
    } vec_t;

    vec_t vec[4];

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return {8'hA5, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic v, input logic [23:0] a);
        if (port) begin
            bus.p1_valid = v;
            bus.p1_addr  = a;
        end else begin
            bus.p0_valid = v;
            bus.p0_addr  = a;
        end
    endtask

    // Issues n back-to-back reads on one port, keeping valid high between them.
    task automatic requester(input logic port, input int n, input logic [23:0] base,
                             input logic [23:0] step);
        for (int i = 0; i < n; i++) begin
            logic [23:0] a;
            logic [31:0] exp_d;
            logic [31:0] act_d;
            int          w;
            logic        got;
            a = base + step * 24'(i);
            drive(port, 1'b1, a);
            if (port) sb_q1.push_back(mem_word(word_align(a)));
            else      sb_q0.push_back(mem_word(word_align(a)));
            w   = 0;
            got = 1'b0;
            while (!got && w < 500) begin
                tick();
                w++;
                got = port ? bus.p1_ready : bus.p0_ready;
            end
            if (!got) begin
                check($sformatf("p%0d_timeout_req%0d", port, i), 32'd0, 32'd1);
                drive(port, 1'b0, a);
                return;
            end
            if (port) begin
                exp_d = sb_q1.pop_front();
                act_d = bus.p1_rdata;
            end else begin
                exp_d = sb_q0.pop_front();
                act_d = bus.p0_rdata;
            end
            check($sformatf("p%0d_rdata_%06h", port, a), act_d, exp_d);
            grant_order.push_back(int'(port));
            $display("port%0d read 0x%06h -> 0x%08h", port, a, act_d);
            if (i == n - 1) drive(port, 1'b0, a);
        end
    endtask

    // exp_bits[i] is the port expected for the i-th completed read.
    task automatic check_grants(input string name, input logic [15:0] exp_bits, input int n);
        check({name, "_count"}, 32'(grant_order.size()), 32'(n));
        for (int i = 0; i < n && i < grant_order.size(); i++) begin
            check($sformatf("%s_grant%0d", name, i), 32'(grant_order[i]), 32'(exp_bits[i]));
        end
    endtask

    task automatic clear_sb();
        grant_order.delete();
        sb_q0.delete();
        sb_q1.delete();
    endtask

    // spimemio model: answers mem_lat cycles after mem_valid is seen.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                busy_cnt      = 0;
            end else if (bus.mem_valid && !reset) begin
                busy_cnt++;
                if (busy_cnt >= mem_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = use_fixed ? fixed_data : mem_word(bus.mem_addr);
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // mem_valid must stay low for at least two cycles between reads.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                seen_high = 1'b0;
                low_run   = 0;
            end else if (bus.mem_valid) begin
                if (seen_high && low_run > 0) check("mem_valid_gap", 32'(low_run >= 2), 32'd1);
                seen_high = 1'b1;
                low_run   = 0;
            end else if (seen_high) begin
                low_run++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{1'b0, 24'h000100, 20, 32'hDEADBEEF, 24'h000100};
        vec[1] = '{1'b0, 24'h000103,  3, 32'h12345678, 24'h000100};
        vec[2] = '{1'b1, 24'h000010,  1, 32'hCAFEF00D, 24'h000010};
        vec[3] = '{1'b1, 24'hFFFFFE,  5, 32'h0BADC0DE, 24'hFFFFFC};

        reset        = 1'b1;
        bus.p0_valid = 1'b0;
        bus.p0_addr  = 24'h0;
        bus.p1_valid = 1'b0;
        bus.p1_addr  = 24'h0;
        repeat (3) tick();
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_p0_ready",  32'(bus.p0_ready),  32'd0);
        check("rst_p1_ready",  32'(bus.p1_ready),  32'd0);
        check("rst_p0_rdata",  bus.p0_rdata,       32'd0);
        check("rst_p1_rdata",  bus.p1_rdata,       32'd0);
        reset = 1'b0;
        tick();

        // Table: single requests, latency, alignment, response strobe timing.
        use_fixed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int   w;
            logic rdy;
            logic ordy;
            logic [31:0] rd;
            mem_lat    = vec[i].lat;
            fixed_data = vec[i].data;
            drive(vec[i].port, 1'b1, vec[i].addr);
            tick();
            check($sformatf("vec%0d_mem_valid", i), 32'(bus.mem_valid), 32'd1);
            check($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vec[i].exp_addr));
            w = 0;
            while (!bus.mem_ready && w < 200) begin
                tick();
                w++;
            end
            if (!bus.mem_ready) check($sformatf("vec%0d_mem_ready_timeout", i), 32'd0, 32'd1);
            rdy = vec[i].port ? bus.p1_ready : bus.p0_ready;
            check($sformatf("vec%0d_ready_early", i), 32'(rdy), 32'd0);
            tick();
            rdy  = vec[i].port ? bus.p1_ready : bus.p0_ready;
            ordy = vec[i].port ? bus.p0_ready : bus.p1_ready;
            rd   = vec[i].port ? bus.p1_rdata : bus.p0_rdata;
            check($sformatf("vec%0d_ready", i), 32'(rdy), 32'd1);
            check($sformatf("vec%0d_rdata", i), rd, vec[i].data);
            check($sformatf("vec%0d_other_ready", i), 32'(ordy), 32'd0);
            check($sformatf("vec%0d_mem_valid_low", i), 32'(bus.mem_valid), 32'd0);
            $display("vec%0d port%0d addr 0x%06h -> 0x%08h", i, vec[i].port, vec[i].addr, rd);
            drive(vec[i].port, 1'b0, vec[i].addr);
            tick();
            rdy = vec[i].port ? bus.p1_ready : bus.p0_ready;
            check($sformatf("vec%0d_ready_drop", i), 32'(rdy), 32'd0);
        end
        use_fixed = 1'b0;
        mem_lat   = 2;

        // Round-robin: both ports streaming, addresses never sequential.
        clear_sb();
        fork
            requester(1'b0, 4, 24'h001000, 24'h000100);
            requester(1'b1, 4, 24'h002000, 24'h000100);
        join
        check_grants("rr", 16'h00AA, 8);
        repeat (3) tick();

        // Affinity and burst limit.
        clear_sb();
        requester(1'b0, 1, 24'h000200, 24'h0);
        grant_order.delete();
        fork
            requester(1'b0, 9, 24'h000204, 24'h000004);
            requester(1'b1, 2, 24'h008000, 24'h000004);
        join
`ifdef SPIMEM_ARB_STREAM_EN
        check_grants("affinity", 16'h0300, 11);
`else
        check_grants("affinity", 16'h0005, 11);
`endif
        repeat (3) tick();

        // Stream wrap from 0xFFFFFC to 0x000000.
        clear_sb();
        requester(1'b1, 1, 24'hFFFFFC, 24'h0);
        grant_order.delete();
        fork
            requester(1'b1, 1, 24'h000000, 24'h0);
            requester(1'b0, 1, 24'h000400, 24'h0);
        join
`ifdef SPIMEM_ARB_STREAM_EN
        check_grants("wrap", 16'h0001, 2);
`else
        check_grants("wrap", 16'h0002, 2);
`endif
        repeat (3) tick();

        // Reset while a read is outstanding.
        clear_sb();
        mem_lat = 50;
        drive(1'b0, 1'b1, 24'h000300);
        tick();
        check("midrst_mem_valid_before", 32'(bus.mem_valid), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("midrst_p0_ready",  32'(bus.p0_ready),  32'd0);
        check("midrst_p1_ready",  32'(bus.p1_ready),  32'd0);
        check("midrst_p0_rdata",  bus.p0_rdata,       32'd0);
        drive(1'b0, 1'b0, 24'h000300);
        reset = 1'b0;
        tick();
        check("postrst_p0_ready", 32'(bus.p0_ready), 32'd0);
        mem_lat = 4;
        requester(1'b1, 1, 24'h000010, 24'h0);
        check_grants("postrst", 16'h0001, 1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
